// File: rtl/vcd4_rle.sv
// vcd4_rle -- half-step down counter with terminal count and cascade enable.
//
// The 5-bit state Q = {Y, ph} counts down by one per enabled clock. Y is the
// visible 4-bit count and ph is a half-step phase bit, so Y steps once every
// two enable pulses. At Q == 0 the terminal count flag is raised. The next
// enabled edge reloads {TOP, 1} instead of wrapping, which gives 2*TOP+2 enable
// pulses per full cycle.
//
// Optional feature: define VCD_LOAD_EN to add a synchronous parallel load
// (ports l, di). A load sets Q = {di, 1}.
//
// Ports
//   clk  in   clock, all state changes on the rising edge
//   r    in   synchronous active-high reset, sets Q = {TOP, 1}
//   ce   in   count enable
//   l    in   parallel load strobe       (VCD_LOAD_EN only)
//   di   in   [3:0] parallel load value  (VCD_LOAD_EN only)
//   Y    out  [3:0] visible count
//   TC   out  terminal count, high when Q == 0
//   CEO  out  cascade enable out, ce & TC (combinational)
module vcd4_rle #(
   parameter int TOP = 8
) (
   input  logic       clk,
   input  logic       r,
   input  logic       ce,
`ifdef VCD_LOAD_EN
   input  logic       l,
   input  logic [3:0] di,
`endif
   output logic [3:0] Y,
   output logic       TC,
   output logic       CEO
);

   localparam logic [4:0] RELOAD = {TOP[3:0], 1'b1};

   // Power-up value matches the reset value.
   logic [4:0] q_q = RELOAD;
   logic [4:0] q_d;

   assign Y   = q_q[4:1];
   assign TC  = (q_q == 5'd0);
   assign CEO = ce & TC;

   // Reset is applied in the register below; this covers load/reload/count.
   always_comb begin
      q_d = q_q;
`ifdef VCD_LOAD_EN
      if (l) begin
         // A load wins over the terminal-count reload even while CEO is high.
         q_d = {di, 1'b1};
      end else
`endif
      if (CEO) begin
         q_d = RELOAD;
      end else if (ce) begin
         q_d = q_q - 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (r) begin
         q_q <= RELOAD;
      end else begin
         q_q <= q_d;
      end
   end

endmodule

// File: tb/tb_vcd4_rle.sv
// Testbench for vcd4_rle (TOP = 8). Vectors carry the inputs for one clock
// plus the CEO value expected before the edge and the Y/TC values expected
// after it. Expected post-edge values go through a scoreboard queue.
module tb_vcd4_rle;

   logic       clk = 1'b0;
   logic       r   = 1'b0;
   logic       ce  = 1'b0;
`ifdef VCD_LOAD_EN
   logic       l   = 1'b0;
   logic [3:0] di  = 4'd0;
`endif
   logic [3:0] Y;
   logic       TC;
   logic       CEO;

   vcd4_rle #(.TOP(8)) dut (
      .clk (clk),
      .r   (r),
      .ce  (ce),
`ifdef VCD_LOAD_EN
      .l   (l),
      .di  (di),
`endif
      .Y   (Y),
      .TC  (TC),
      .CEO (CEO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic       ce;
      logic       l;
      logic [3:0] di;
      logic       ceo;  // expected CEO before the edge
      logic [3:0] y;    // expected Y after the edge
      logic       tc;   // expected TC after the edge
   } vec_t;

   typedef struct {
      logic [3:0] y;
      logic       tc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic void add(input logic rr, input logic cc, input logic ll,
                               input logic [3:0] dd, input logic eceo,
                               input logic [3:0] ey, input logic etc);
      vec_t v;
      v.r = rr; v.ce = cc; v.l = ll; v.di = dd;
      v.ceo = eceo; v.y = ey; v.tc = etc;
      vecs.push_back(v);
   endfunction

   // k-th enable pulse after a reload: Q = 17 - k, so Y = (17 - k) / 2.
   function automatic logic [3:0] y_after(input int k);
      return 4'((17 - k) / 2);
   endfunction

   task automatic check_bit(input string name, input logic act, input logic req);
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset edge, then 17 pulses down to TC, hold at TC, then reload.
      add(1, 0, 0, 0, 0, 4'd8, 0);
      for (int k = 1; k <= 17; k++) add(0, 1, 0, 0, 0, y_after(k), (k == 17));
      add(0, 0, 0, 0, 0, 4'd0, 1);
      add(0, 0, 0, 0, 0, 4'd0, 1);
      add(0, 1, 0, 0, 1, 4'd8, 0);
      add(0, 1, 0, 0, 0, 4'd8, 0);

      // 5 pulses, 10 idle cycles hold Y=6; next pulse drops Y at once (ph was 0).
      add(1, 0, 0, 0, 0, 4'd8, 0);
      for (int k = 1; k <= 5; k++) add(0, 1, 0, 0, 0, y_after(k), 0);
      for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 0, 4'd6, 0);
      add(0, 1, 0, 0, 0, 4'd5, 0);

      // Reset mid-count with ce high, then 18 pulses to the next CEO.
      add(1, 0, 0, 0, 0, 4'd8, 0);
      for (int k = 1; k <= 7; k++) add(0, 1, 0, 0, 0, y_after(k), 0);
      add(1, 1, 0, 0, 0, 4'd8, 0);
      for (int k = 1; k <= 17; k++) add(0, 1, 0, 0, 0, y_after(k), (k == 17));
      add(0, 1, 0, 0, 1, 4'd8, 0);

`ifdef VCD_LOAD_EN
      // Load 3, count 7 to TC, then reset beats a simultaneous load.
      add(1, 0, 0, 0, 0, 4'd8, 0);
      add(0, 0, 1, 3, 0, 4'd3, 0);
      add(0, 1, 0, 0, 0, 4'd3, 0);
      add(0, 1, 0, 0, 0, 4'd2, 0);
      add(0, 1, 0, 0, 0, 4'd2, 0);
      add(0, 1, 0, 0, 0, 4'd1, 0);
      add(0, 1, 0, 0, 0, 4'd1, 0);
      add(0, 1, 0, 0, 0, 4'd0, 0);
      add(0, 1, 0, 0, 0, 4'd0, 1);
      add(1, 0, 1, 5, 0, 4'd8, 0);

      // Load coinciding with CEO takes the load value.
      for (int k = 1; k <= 17; k++) add(0, 1, 0, 0, 0, y_after(k), (k == 17));
      add(0, 1, 1, 2, 1, 4'd2, 0);
      // di = 0 loads Q = 1; one pulse reaches TC.
      add(0, 0, 1, 0, 0, 4'd0, 0);
      add(0, 1, 0, 0, 0, 4'd0, 1);
      // Load with ce low while in TC.
      add(0, 0, 1, 4, 0, 4'd4, 0);
`endif

      // Power-up value equals reset value, checked before any edge.
      #1;
      n_vec++;
      if (Y !== 4'd8 || TC !== 1'b0 || CEO !== 1'b0) begin
         n_err++;
         $display("FAIL powerup: got Y=%0d TC=%b CEO=%b, expected Y=8 TC=0 CEO=0",
                  Y, TC, CEO);
      end

      foreach (vecs[i]) begin
         exp_t e;
         @(negedge clk);
         r  = vecs[i].r;
         ce = vecs[i].ce;
`ifdef VCD_LOAD_EN
         l  = vecs[i].l;
         di = vecs[i].di;
`endif
         e.y  = vecs[i].y;
         e.tc = vecs[i].tc;
         sb.push_back(e);
         #1;
         n_vec++;
         check_bit($sformatf("ceo[%0d]", i), CEO, vecs[i].ceo);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard[%0d]: queue empty, expected one entry", i);
         end else begin
            e = sb.pop_front();
            if (Y !== e.y) begin
               n_err++;
               $display("FAIL y[%0d]: got %0d, expected %0d", i, Y, e.y);
            end
            check_bit($sformatf("tc[%0d]", i), TC, e.tc);
         end
      end

      @(negedge clk);
      r  = 1'b0;
      ce = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
